// File: rtl/cache_wb_pkg.sv
// Shared types, default widths and the memory word-address builder for the write-back engine.
package cache_wb_pkg;

  localparam int DEF_WORDS  = 4;
  localparam int DEF_TAG_W  = 5;
  localparam int DEF_IDX_W  = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ISSUE,
    CLEAR,
    DONE
  } state_t;

  // Word address: bit 0 is always zero because memory is byte-addressed per 16-bit word.
  function automatic logic [15:0] mem_addr_f(input logic [DEF_TAG_W-1:0] tag,
                                             input logic [DEF_IDX_W-1:0] idx,
                                             input logic [1:0]           off);
    return {tag, idx, off, 1'b0};
  endfunction

endpackage

// File: rtl/cache_wb_linebuf.sv
// Victim-line capture register: loads a whole line at once, reads one word at a time.
module cache_wb_linebuf #(
  parameter int WORDS  = 4,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    load,
  input  logic [WORDS*DATA_W-1:0] din,
  input  logic [1:0]              sel,
  output logic [DATA_W-1:0]       dout
);

  logic [DATA_W-1:0] words [WORDS];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < WORDS; i++) words[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS; i++) words[i] <= din[i*DATA_W +: DATA_W];
    end
  end

  assign dout = words[sel];

endmodule

// File: rtl/cache_wb_engine.sv
// Dirty-line eviction engine: captures a victim line from the cache arrays and drains it to memory.
// Optional statistics counters are built when CACHE_WB_STATS_EN is defined.
module cache_wb_engine
  import cache_wb_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [IDX_W-1:0]        index,
  output logic [IDX_W-1:0]        arr_addr,
  input  logic [WORDS*DATA_W-1:0] arr_data,
  input  logic [TAG_W-1:0]        arr_tag,
  input  logic                    arr_dirty,
  output logic                    dirty_wr,
  output logic [15:0]             mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    mem_wr,
  input  logic                    mem_stall,
  output logic                    busy,
  output logic                    done
`ifdef CACHE_WB_STATS_EN
  ,
  output logic [15:0]             evict_cnt,
  output logic [15:0]             stall_cnt
`endif
);

  localparam logic [1:0] LAST = 2'(WORDS - 1);

  state_t            state, nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [1:0]        cnt;
  logic              load;
  logic [DATA_W-1:0] word;

  cache_wb_linebuf #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clk   (clk),
    .clr_n (rst_n),
    .load  (load),
    .din   (arr_data),
    .sel   (cnt),
    .dout  (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx_q <= '0;
      tag_q <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) idx_q <= index;
      if (state == CAPTURE) begin
        tag_q <= arr_tag;
        cnt   <= '0;
      end
      if (state == ISSUE && !mem_stall) cnt <= cnt + 2'd1;
    end
  end

  always_comb begin
    nxt      = state;
    arr_addr = '0;
    dirty_wr = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    done     = 1'b0;
    busy     = 1'b1;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = CAPTURE;
      end
      CAPTURE: begin
        arr_addr = idx_q;
        load     = 1'b1;
        nxt      = arr_dirty ? ISSUE : DONE;
      end
      ISSUE: begin
        mem_wr   = 1'b1;
        mem_data = word;
        mem_addr = mem_addr_f(tag_q, idx_q, cnt);
        if (!mem_stall && cnt == LAST) nxt = CLEAR;
      end
      CLEAR: begin
        arr_addr = idx_q;
        dirty_wr = 1'b1;
        nxt      = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef CACHE_WB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evict_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == CLEAR) evict_cnt <= sat_inc(evict_cnt);
      if (state == ISSUE && mem_stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

  // A capture must see a stable line: nothing of ours may write the arrays while they are read.
  a_capture_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state == CAPTURE) |-> (!dirty_wr && arr_addr == idx_q));

endmodule
